// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants, monitor state encoding and counter widths
// for the VGA generator and its receive-side sync monitor.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int COL_W   = 11;
  localparam int ROW_W   = 10;
  localparam int LINE_W  = 11;
  localparam int FRAME_W = 10;
  localparam int GOOD_W  = 4;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } mon_state_t;

endpackage

// File: rtl/vga_edge_detect.sv
// Strobe-qualified previous-sample register producing fall/rise flags for one
// sync/blank line; the history resets high so a low input right after reset reads as a fall.
module vga_edge_detect (
  input  logic clk,
  input  logic rst_b,
  input  logic ce,
  input  logic d,
  output logic fall,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev <= 1'b1;
    end else if (ce) begin
      prev <= d;
    end
  end

  assign fall = ce & prev & ~d;
  assign rise = ce & ~prev & d;

endmodule

// File: rtl/vga_sync_monitor.sv
// Recovers pixel coordinates from a VGA sync/blank stream, measures line and
// frame geometry and tracks lock. Define VGA_MON_STATS_EN for frame/error counters.
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        pix_ce,
  input  logic        hs_n,
  input  logic        vs_n,
  input  logic        blank_n,
  input  logic        err_clr,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err_sticky,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas
`ifdef VGA_MON_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [COL_W-1:0]   H_ACTIVE_C = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0]  H_TOTAL_C  = LINE_W'(H_TOTAL);
  localparam logic [ROW_W-1:0]   V_ACTIVE_C = ROW_W'(V_ACTIVE);
  localparam logic [FRAME_W-1:0] V_TOTAL_C  = FRAME_W'(V_TOTAL);
  localparam logic [GOOD_W-1:0]  LOCK_C     = GOOD_W'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic hs_fall, vs_fall, bl_fall, bl_rise;
  logic unused_hs_rise, unused_vs_rise;

  vga_edge_detect u_hs (.clk(clk), .rst_b(rst_b), .ce(pix_ce), .d(hs_n),
                        .fall(hs_fall), .rise(unused_hs_rise));
  vga_edge_detect u_vs (.clk(clk), .rst_b(rst_b), .ce(pix_ce), .d(vs_n),
                        .fall(vs_fall), .rise(unused_vs_rise));
  vga_edge_detect u_bl (.clk(clk), .rst_b(rst_b), .ce(pix_ce), .d(blank_n),
                        .fall(bl_fall), .rise(bl_rise));

  logic [COL_W-1:0]   col_cnt, col_cur;
  logic [ROW_W-1:0]   row_cnt, row_inc;
  logic [LINE_W-1:0]  line_cnt, h_new;
  logic [FRAME_W-1:0] frm_cnt, frm_inc;
  logic               err_line, err_frame, err_now, lock_loss;
  mon_state_t         state;
  logic [GOOD_W-1:0]  good_cnt;
  logic               frame_err;

  // Boundary evaluation: values as they stand including this sample's edge
  always_comb begin
    col_cur   = bl_rise ? '0 : col_cnt;
    h_new     = sat_inc11(line_cnt);
    row_inc   = bl_fall ? sat_inc10(row_cnt) : row_cnt;
    frm_inc   = hs_fall ? sat_inc10(frm_cnt) : frm_cnt;
    err_line  = (hs_fall && (h_new != H_TOTAL_C)) || (bl_fall && (col_cnt != H_ACTIVE_C));
    err_frame = vs_fall && ((frm_inc != V_TOTAL_C) || (row_inc != V_ACTIVE_C));
    err_now   = err_line | err_frame;
    lock_loss = (state == LOCKED) && err_now;
  end

  // Coordinate recovery and geometry measurement
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      line_cnt    <= '0;
      frm_cnt     <= '0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        if (blank_n) begin
          pix_valid <= 1'b1;
          pix_x     <= col_cur[9:0];
          pix_y     <= row_cnt;
          col_cnt   <= sat_inc11(col_cur);
        end
        row_cnt  <= vs_fall ? '0 : row_inc;
        line_cnt <= hs_fall ? '0 : sat_inc11(line_cnt);
        frm_cnt  <= vs_fall ? '0 : frm_inc;
        if (hs_fall) begin
          h_meas <= h_new;
        end
        if (vs_fall) begin
          v_meas      <= frm_inc;
          frame_start <= 1'b1;
        end
      end
    end
  end

  // Lock FSM; the partial frame seen in SEARCH is never judged
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (pix_ce) begin
        frame_err <= vs_fall ? 1'b0 : (frame_err | err_line);
        case (state)
          SEARCH: begin
            if (vs_fall) begin
              good_cnt <= '0;
              state    <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (vs_fall) begin
              if (frame_err || err_now) begin
                good_cnt <= '0;
              end else if (good_cnt + 4'd1 >= LOCK_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end
          end
          LOCKED: begin
            if (err_now) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
      if (lock_loss) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

`ifdef VGA_MON_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (vs_fall) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (lock_loss) begin
        err_cnt <= sat_inc8(err_cnt);
      end else if (err_clr) begin
        err_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a scaled-down raster with random strobe spacing.
module tb_vga_sync_monitor;

  localparam int HA = 16, HT = 24, VA = 8, VT = 14, LK = 2;
  localparam int HS_BEG = 18, HS_END = 21, VS_BEG = 10, VS_END = 12;

  logic        clk = 1'b0, rst_b = 1'b0, pix_ce = 1'b0;
  logic        hs_n = 1'b1, vs_n = 1'b1, blank_n = 1'b0, err_clr = 1'b0;
  logic [9:0]  pix_x, pix_y, v_meas;
  logic        pix_valid, frame_start, locked, err_sticky;
  logic [10:0] h_meas;
`ifdef VGA_MON_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  vga_sync_monitor #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
                     .LOCK_FRAMES(LK)) dut (
    .clk(clk), .rst_b(rst_b), .pix_ce(pix_ce), .hs_n(hs_n), .vs_n(vs_n),
    .blank_n(blank_n), .err_clr(err_clr), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .frame_start(frame_start), .locked(locked),
    .err_sticky(err_sticky), .h_meas(h_meas), .v_meas(v_meas)
`ifdef VGA_MON_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct { int x; int y; int c; } pix_t;
  typedef struct { int v; int h; int lk; int st; int c; } frm_t;
  pix_t pixq[$];
  frm_t frmq[$];
  int   riseq[$];
  int   lossq[$];

  // Reference model: stream history and frame bookkeeping
  bit m_hs, m_vs, m_bl, synced, bad, locked_m, sticky;
  int m_line, m_col, m_rows, m_hsf, last_h, run;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_hs = 1; m_vs = 1; m_bl = 1;
    m_line = 0; m_col = 0; m_rows = 0; m_hsf = 0; last_h = 0;
    synced = 0; bad = 0; locked_m = 0; sticky = 0; run = 0;
  endfunction

  task automatic strobe(input bit hs, input bit vs, input bit bl, input bit clr);
    bit hf, vf, bf, br, err, set;
    int x, v, c;
    c = cyc;
    hs_n = hs; vs_n = vs; blank_n = bl; err_clr = clr; pix_ce = 1'b1;
    hf = m_hs & ~hs; vf = m_vs & ~vs; bf = m_bl & ~bl; br = ~m_bl & bl;
    err = 0; set = 0; v = 0;
    m_line++;
    if (bl) begin
      x = br ? 0 : m_col;
      pixq.push_back('{x, m_rows, c + 1});
      m_col = x + 1;
    end
    if (hf) begin
      last_h = (m_line > 2047) ? 2047 : m_line;
      m_line = 0;
      m_hsf++;
      if (last_h != HT) err = 1;
    end
    if (bf) begin
      if (m_col != HA) err = 1;
      m_rows++;
    end
    if (vf) begin
      v = (m_hsf > 1023) ? 1023 : m_hsf;
      if (v != VT || m_rows != VA) err = 1;
      m_hsf = 0;
      m_rows = 0;
    end
    if (locked_m) begin
      if (err) begin
        locked_m = 0; synced = 0; set = 1;
        lossq.push_back(c + 1);
      end
    end else if (vf) begin
      if (!synced) begin
        synced = 1; run = 0;
      end else begin
        run = (bad || err) ? 0 : run + 1;
        if (run >= LK) begin
          locked_m = 1;
          riseq.push_back(c + 1);
        end
      end
      bad = 0;
    end else if (err) begin
      bad = 1;
    end
    if (set) sticky = 1;
    else if (clr) sticky = 0;
    if (vf) frmq.push_back('{v, last_h, int'(locked_m), int'(sticky), c + 1});
    m_hs = hs; m_vs = vs; m_bl = bl;
    @(posedge clk); #1;
    pix_ce = 1'b0; err_clr = 1'b0;
    repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_line(input int v, input int len, input int clr_h);
    for (int h = 0; h < len; h++)
      strobe(!(h >= HS_BEG && h < HS_END), !(v >= VS_BEG && v < VS_END),
             (v < VA) && (h < HA), h == clr_h);
  endtask

  task automatic send_frame(input int first, input int last, input int stretch,
                            input int clr_v, input int clr_h);
    for (int v = first; v <= last; v++)
      send_line(v, (v == stretch) ? HT + 1 : HT, (v == clr_v) ? clr_h : -1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix_x"}, int'(pix_x), 0);
    chk({tag, "_pix_y"}, int'(pix_y), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err_sticky"}, int'(err_sticky), 0);
    chk({tag, "_h_meas"}, int'(h_meas), 0);
    chk({tag, "_v_meas"}, int'(v_meas), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_b = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    repeat (2) begin @(posedge clk); #1; end
    rst_b = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event
  initial begin
    bit   lk_prev;
    pix_t p;
    frm_t f;
    int   e;
    lk_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        lk_prev = 0;
      end else begin
        if (pix_valid) begin
          chk("pix_expected", int'(pixq.size() > 0), 1);
          if (pixq.size() > 0) begin
            p = pixq.pop_front();
            chk("pix_cycle", cyc, p.c);
            chk("pix_x", int'(pix_x), p.x);
            chk("pix_y", int'(pix_y), p.y);
          end
        end
        if (frame_start) begin
          chk("frame_expected", int'(frmq.size() > 0), 1);
          if (frmq.size() > 0) begin
            f = frmq.pop_front();
            chk("frame_cycle", cyc, f.c);
            chk("frame_v_meas", int'(v_meas), f.v);
            chk("frame_h_meas", int'(h_meas), f.h);
            chk("frame_locked", int'(locked), f.lk);
            chk("frame_err_sticky", int'(err_sticky), f.st);
          end
        end
        if (locked && !lk_prev) begin
          chk("lock_rise_expected", int'(riseq.size() > 0), 1);
          if (riseq.size() > 0) begin
            e = riseq.pop_front();
            chk("lock_rise_cycle", cyc, e);
          end
        end
        if (!locked && lk_prev) begin
          chk("lock_loss_expected", int'(lossq.size() > 0), 1);
          if (lossq.size() > 0) begin
            e = lossq.pop_front();
            chk("lock_loss_cycle", cyc, e);
          end
          chk("lock_loss_sticky", int'(err_sticky), 1);
        end
        lk_prev = locked;
      end
    end
  end

  initial begin
    int l;
    model_reset();
    #1;
    check_zero("por");
    repeat (3) begin @(posedge clk); #1; end
    rst_b = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Clean stream: first frame partial, two clean frames, lock at third vs fall
    send_frame(0, VT - 1, -1, -1, -1);
    chk("locked_after_1", int'(locked), 0);
    send_frame(0, VT - 1, -1, -1, -1);
    chk("locked_after_2", int'(locked), 0);
    send_frame(0, VT - 1, -1, -1, -1);
    chk("locked_after_3", int'(locked), 1);
    chk("h_meas_clean", int'(h_meas), HT);
    chk("v_meas_clean", int'(v_meas), VT);
    chk("sticky_clean", int'(err_sticky), 0);
    send_frame(0, VT - 1, -1, -1, -1);

    // One stretched line drops lock; relock afterwards
    l = $urandom_range(1, 6);
    send_frame(0, VT - 1, l, -1, -1);
    chk("locked_after_stretch", int'(locked), 0);
    chk("sticky_after_stretch", int'(err_sticky), 1);
    repeat (3) send_frame(0, VT - 1, -1, -1, -1);
    chk("relocked", int'(locked), 1);

    // err_clr coincident with a new lock loss: set wins
    l = $urandom_range(1, 6);
    send_frame(0, VT - 1, l, l + 1, HS_BEG);
    chk("sticky_set_wins", int'(err_sticky), 1);
    chk("locked_after_clr_loss", int'(locked), 0);
    send_frame(0, VT - 1, -1, 2, 0);
    repeat (2) send_frame(0, VT - 1, -1, -1, -1);
    chk("sticky_cleared", int'(err_sticky), 0);
    chk("relocked_2", int'(locked), 1);

    // Mid-frame async reset, then frames one line short never lock
    send_frame(0, 2, -1, -1, -1);
    do_reset("midrst");
    send_frame(3, VT - 1, -1, -1, -1);
    repeat (4) send_frame(0, VT - 2, -1, -1, -1);
    chk("short_v_meas", int'(v_meas), VT - 1);
    chk("short_locked", int'(locked), 0);
    chk("short_sticky", int'(err_sticky), 0);

    // hs held high long enough to saturate the line counter
    repeat (3000) strobe(1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 0, -1, -1, -1);
    chk("h_meas_saturated", int'(h_meas), 2047);
    chk("sat_locked", int'(locked), 0);
    send_frame(1, VT - 1, -1, -1, -1);
    repeat (3) send_frame(0, VT - 1, -1, -1, -1);
    chk("relocked_after_sat", int'(locked), 1);

    repeat (5) begin @(posedge clk); #1; end
    chk("pixq_drained", int'(pixq.size()), 0);
    chk("frmq_drained", int'(frmq.size()), 0);
    chk("riseq_drained", int'(riseq.size()), 0);
    chk("lossq_drained", int'(lossq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
